spi_burst_engine: RTL and testbench
===================================

// Module: spi_burst_engine
// PURPOSE
//  Parametrised SPI master for nRF24-class radios; one command byte plus 0..MAX_BURST payload bytes per CSN frame.
//  Captures STATUS, the MISO byte clocked during the command byte, and flags RX_DR directly.
//  Sits between the control FSM and the radio pins; TX bytes arrive by valid/ready, RX bytes leave as DV pulses.
// PARAMETERS
//  CLKS_PER_HALF_BIT  2    i_Clk cycles per SCK half-period (>=1)
//  MAX_BURST          32   max payload bytes per frame
//  LEN_W              6    width of i_Len (must hold MAX_BURST)
//  CS_GUARD           4    i_Clk cycles CSN stays high between frames
//  TIMEOUT_CYCLES     1024 TX-stall abort limit (used only with SPI_BURST_TIMEOUT_EN)
// PORTS
//  i_Clk        in   1      system clock
//  i_Rst        in   1      asynchronous, active-low reset
//  i_Cmd_DV     in   1      command valid
//  i_Cmd        in   8      command opcode
//  i_Len        in   LEN_W  payload byte count
//  o_Cmd_Ready  out  1      engine idle, command accepted
//  i_TX_DV      in   1      payload byte valid
//  i_TX_Byte    in   8      payload byte (0xFF dummy for reads)
//  o_TX_Ready   out  1      engine waiting for next payload byte
//  o_RX_DV      out  1      1-cycle pulse, o_RX_Byte valid
//  o_RX_Byte    out  8      received payload byte
//  o_Status     out  8      last captured STATUS byte
//  o_Status_DV  out  1      1-cycle pulse on STATUS capture
//  o_RX_DR_Set  out  1      o_Status[6], held until next capture
//  o_Len_Err    out  1      1-cycle pulse, i_Len > MAX_BURST (clamped)
//  o_Done       out  1      1-cycle pulse at CSN rising edge
//  o_Abort      out  1      1-cycle pulse on timeout abort (tied 0 without macro)
//  o_SPI_Clk    out  1      SCK, mode 0 (CPOL=0, CPHA=0)
//  o_SPI_Mosi   out  1      MOSI, MSB first
//  i_SPI_Miso   in   1      MISO, sampled on SCK rising edge
//  o_SPI_Csn    out  1      chip select, active low
// BEHAVIOUR
//  Reset (async, any state): IDLE; Csn=1, Clk=0, Mosi=0, Status=0, RX_Byte=0, all pulses/ready=0.
//  Cmd_Ready=1 only in IDLE; Cmd_DV while busy ignored. Accept latches Cmd and min(Len,MAX_BURST).
//  FSM: IDLE -> SETUP -> SHIFT_CMD -> {WAIT_TX -> SHIFT_DATA}*Len -> HOLD -> GUARD -> IDLE.
//  SETUP: Csn=0 the cycle after accept; MSB presented on Mosi; first SCK rise CLKS_PER_HALF_BIT cycles later.
//  Byte = 8 SCK periods = 16*CLKS_PER_HALF_BIT cycles; Mosi changes on SCK fall; Miso sampled on SCK rise.
//  After the 8th fall of the command byte: Status captured, Status_DV pulses, RX_DR_Set updates.
//  WAIT_TX: TX_Ready=1, SCK low, Csn low; byte taken on TX_DV&TX_Ready (same cycle TX_Ready drops).
//  Stall in WAIT_TX is unbounded (no SCK toggling); with TX_DV held high, bytes are back-to-back (1-cycle gap).
//  Each data byte: RX_DV pulse with RX_Byte after its 8th SCK fall.
//  Len=0: command-only frame. Len>MAX_BURST: clamp, Len_Err pulses in the accept+1 cycle.
//  HOLD: CLKS_PER_HALF_BIT cycles, then Csn=1 and Done pulses; GUARD: CS_GUARD cycles, Cmd_Ready=0.
//  TX_DV outside WAIT_TX ignored; Miso ignored while Csn=1.
// CONFIGURATION
//  SPI_BURST_TIMEOUT_EN defined: counter in WAIT_TX; at TIMEOUT_CYCLES without TX_DV -> Csn=1,
//   Abort pulses (Done does not), then GUARD. Undefined: no counter, o_Abort tied 0, waits forever.
// STRUCTURE
//  Package spi_burst_pkg: FSM state encodings; STATUS bit indices (RX_DR=6, TX_DS=5, MAX_RT=4, TX_FULL=0);
//   opcodes R_REGISTER=8'h00, W_REGISTER=8'h20, R_RX_PAYLOAD=8'h61, W_TX_PAYLOAD=8'hA0, NOP=8'hFF.
//  Sub-module spi_bit_shifter: SCK divider + 8-bit shift/sample, start/byte_done handshake; top holds FSM.
// TESTING
//  Cmd=8'hFF, Len=0, slave STATUS=8'h4E -> one byte on Mosi, Status=8'h4E, RX_DR_Set=1, Done once, 8 SCK.
//  Cmd=8'h61, Len=3, TX=FF x3, slave sends 0E,11,22,33 -> RX_DV x3 with 11,22,33; 32 SCK.
//  W_TX_PAYLOAD, TX_DV withheld 50 cycles mid-burst -> SCK low, Csn low throughout; resumes with correct bits.
//  Len=40 (MAX_BURST=32) -> Len_Err pulse, exactly 33 bytes clocked.
//  Reset asserted mid-byte 3 -> Csn=1, Clk=0 immediately; after release Cmd_Ready=1 and next frame clean.
//  Macro on, TIMEOUT_CYCLES=16, stall in WAIT_TX -> Abort at cycle 16, Csn=1, no Done; off -> no abort.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the nRF24-class SPI burst engine.
// FSM encodings, STATUS bit positions and radio opcodes.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_CMD,
    ST_WAIT_TX,
    ST_SHIFT_DATA,
    ST_HOLD,
    ST_GUARD
  } state_e;

  localparam int STAT_RX_DR   = 6;
  localparam int STAT_TX_DS   = 5;
  localparam int STAT_MAX_RT  = 4;
  localparam int STAT_TX_FULL = 0;

  localparam logic [7:0] OP_R_REGISTER   = 8'h00;
  localparam logic [7:0] OP_W_REGISTER   = 8'h20;
  localparam logic [7:0] OP_R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] OP_W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] OP_NOP          = 8'hFF;

endpackage

// File: rtl/spi_burst_engine_shifter.sv
// spi_bit_shifter: SCK divider plus one mode-0 byte shift.
// i_Start loads a byte; o_Done pulses after the 8th SCK fall.
module spi_bit_shifter
  import spi_burst_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [7:0] i_Byte,
  input  logic       i_Miso,
  output logic       o_Sck,
  output logic       o_Mosi,
  output logic       o_Done,
  output logic [7:0] o_Rx
);

  localparam int CW = $clog2(CLKS_PER_HALF_BIT + 1);

  logic          active_q, active_d;
  logic          sck_q, sck_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_q, edge_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;

  // Half-bit timing: sample on rise, advance MOSI on every fall but the last
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (i_Start) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      cnt_d    = '0;
      edge_d   = '0;
      tx_d     = i_Byte;
    end else if (active_q) begin
      if (cnt_q == CW'(CLKS_PER_HALF_BIT - 1)) begin
        cnt_d  = '0;
        sck_d  = ~sck_q;
        edge_d = edge_q + 4'd1;
        if (!sck_q) begin
          rx_d = {rx_q[6:0], i_Miso};
        end else if (edge_q == 4'd15) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Shifter state registers
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      edge_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign o_Sck  = sck_q;
  assign o_Mosi = tx_q[7];
  assign o_Done = done_q;
  assign o_Rx   = rx_q;

endmodule

// File: rtl/spi_burst_engine.sv
// SPI burst master: command byte + 0..MAX_BURST payload per CSN frame.
// Define SPI_BURST_TIMEOUT_EN to abort frames stalled in WAIT_TX.
module spi_burst_engine
  import spi_burst_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BURST         = 32,
  parameter int LEN_W             = 6,
  parameter int CS_GUARD          = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Cmd_DV,
  input  logic [7:0]       i_Cmd,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Cmd_Ready,
  input  logic             i_TX_DV,
  input  logic [7:0]       i_TX_Byte,
  output logic             o_TX_Ready,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic [7:0]       o_Status,
  output logic             o_Status_DV,
  output logic             o_RX_DR_Set,
  output logic             o_Len_Err,
  output logic             o_Done,
  output logic             o_Abort,
  output logic             o_SPI_Clk,
  output logic             o_SPI_Mosi,
  input  logic             i_SPI_Miso,
  output logic             o_SPI_Csn
);

  // One counter covers HOLD, GUARD and the optional stall timeout
  localparam int CNT_W =
    $clog2(CS_GUARD + CLKS_PER_HALF_BIT + TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic             csn_q, csn_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       status_q, status_d;
  logic             status_dv_q, status_dv_d;
  logic             rx_dv_q, rx_dv_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             len_err_q, len_err_d;
  logic             done_q, done_d;
  logic             abort_d;

  logic             sh_start;
  logic [7:0]       sh_byte;
  logic             sh_done;
  logic [7:0]       sh_rx;

  spi_bit_shifter #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_shifter (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Start(sh_start),
    .i_Byte (sh_byte),
    .i_Miso (i_SPI_Miso),
    .o_Sck  (o_SPI_Clk),
    .o_Mosi (o_SPI_Mosi),
    .o_Done (sh_done),
    .o_Rx   (sh_rx)
  );

  // Frame sequencing: accept, command byte, payload bytes, hold, guard
  always_comb begin
    state_d     = state_q;
    csn_d       = csn_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    status_dv_d = 1'b0;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    len_err_d   = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    sh_start    = 1'b0;
    sh_byte     = i_Cmd;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Cmd_DV) begin
          sh_start = 1'b1;
          csn_d    = 1'b0;
          state_d  = ST_SETUP;
          if (i_Len > LEN_W'(MAX_BURST)) begin
            rem_d     = LEN_W'(MAX_BURST);
            len_err_d = 1'b1;
          end else begin
            rem_d = i_Len;
          end
        end
      end
      ST_SETUP: state_d = ST_SHIFT_CMD;
      ST_SHIFT_CMD: begin
        if (sh_done) begin
          status_d    = sh_rx;
          status_dv_d = 1'b1;
          cnt_d       = '0;
          state_d     = (rem_q == '0) ? ST_HOLD : ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (i_TX_DV) begin
          sh_start = 1'b1;
          sh_byte  = i_TX_Byte;
          cnt_d    = '0;
          state_d  = ST_SHIFT_DATA;
        end
`ifdef SPI_BURST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          csn_d   = 1'b1;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_SHIFT_DATA: begin
        if (sh_done) begin
          rx_dv_d   = 1'b1;
          rx_byte_d = sh_rx;
          rem_d     = rem_q - 1'b1;
          cnt_d     = '0;
          state_d   = (rem_q == LEN_W'(1)) ? ST_HOLD : ST_WAIT_TX;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CLKS_PER_HALF_BIT - 1)) begin
          csn_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == CNT_W'(CS_GUARD - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= ST_IDLE;
      csn_q       <= 1'b1;
      rem_q       <= '0;
      cnt_q       <= '0;
      status_q    <= '0;
      status_dv_q <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      len_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csn_q       <= csn_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      status_dv_q <= status_dv_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      len_err_q   <= len_err_d;
      done_q      <= done_d;
    end
  end

`ifdef SPI_BURST_TIMEOUT_EN
  logic abort_q;

  // Abort pulse register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) abort_q <= 1'b0;
    else        abort_q <= abort_d;
  end

  assign o_Abort = abort_q;
`else
  logic unused_abort;
  assign unused_abort = abort_d;
  assign o_Abort      = 1'b0;
`endif

  assign o_Cmd_Ready = (state_q == ST_IDLE) && i_Rst;
  assign o_TX_Ready  = (state_q == ST_WAIT_TX);
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_Status    = status_q;
  assign o_Status_DV = status_dv_q;
  assign o_RX_DR_Set = status_q[STAT_RX_DR];
  assign o_Len_Err   = len_err_q;
  assign o_Done      = done_q;
  assign o_SPI_Csn   = csn_q;

endmodule

// File: tb/tb_spi_burst_engine.sv
// Bench for spi_burst_engine with a mode-0 SPI slave model.
// Scoreboard queues hold expected MOSI and RX bytes per frame.
module tb_spi_burst_engine;
  import spi_burst_pkg::*;

  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_dv = 1'b0;
  logic [7:0]    cmd = 8'h00;
  logic [LW-1:0] len = '0;
  logic          cmd_ready;
  logic          tx_dv = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          tx_ready;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [7:0]    status;
  logic          status_dv;
  logic          rx_dr;
  logic          len_err;
  logic          done;
  logic          abort;
  logic          sck;
  logic          mosi;
  logic          miso;
  logic          csn;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_burst_engine #(
    .CLKS_PER_HALF_BIT(2),
    .MAX_BURST(32),
    .LEN_W(LW),
    .CS_GUARD(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst_n),
    .i_Cmd_DV(cmd_dv),
    .i_Cmd(cmd),
    .i_Len(len),
    .o_Cmd_Ready(cmd_ready),
    .i_TX_DV(tx_dv),
    .i_TX_Byte(tx_byte),
    .o_TX_Ready(tx_ready),
    .o_RX_DV(rx_dv),
    .o_RX_Byte(rx_byte),
    .o_Status(status),
    .o_Status_DV(status_dv),
    .o_RX_DR_Set(rx_dr),
    .o_Len_Err(len_err),
    .o_Done(done),
    .o_Abort(abort),
    .o_SPI_Clk(sck),
    .o_SPI_Mosi(mosi),
    .i_SPI_Miso(miso),
    .o_SPI_Csn(csn)
  );

  logic [7:0] slv_q[$];
  logic [7:0] mosi_got[$];
  logic [7:0] rx_got[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];

  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_in = 8'h00;
  int  s_bits = 0;
  int  sck_rises = 0;
  int  n_done = 0;
  int  n_abort = 0;
  int  n_stat = 0;
  int  stall_bad = 0;
  bit  stall_watch = 1'b0;
  logic csn_prev = 1'b1;
  logic sck_prev = 1'b0;

  assign miso = s_sh[7];

  // Slave model and output monitors, sampled on the falling clock
  always @(negedge clk) begin
    if (csn_prev && !csn) begin
      s_bits = 0;
      s_sh = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
    end else if (!csn) begin
      if (!sck_prev && sck) begin
        s_in = {s_in[6:0], mosi};
        s_bits++;
        sck_rises++;
      end
      if (sck_prev && !sck) begin
        if (s_bits == 8) begin
          mosi_got.push_back(s_in);
          s_bits = 0;
          s_sh = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
        end else begin
          s_sh = {s_sh[6:0], 1'b0};
        end
      end
    end
    if (rx_dv) rx_got.push_back(rx_byte);
    if (done) n_done++;
    if (abort) n_abort++;
    if (status_dv) n_stat++;
    if (stall_watch && (sck || csn)) stall_bad++;
    csn_prev = csn;
    sck_prev = sck;
  end

  bit lenerr_seen;

  task automatic start_cmd(input logic [7:0] c,
                           input logic [LW-1:0] l,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    cmd_dv = 1'b1;
    cmd = c;
    len = l;
    @(negedge clk);
    lenerr_seen = len_err;
    cmd_dv = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_sb();
    mosi_got.delete();
    rx_got.delete();
    exp_mosi.delete();
    exp_rx.delete();
    slv_q.delete();
    sck_rises = 0;
  endtask

  task automatic check_sb(input string tag);
    logic [7:0] e, g;
    while (exp_mosi.size() > 0) begin
      e = exp_mosi.pop_front();
      g = (mosi_got.size() > 0) ? mosi_got.pop_front() : 8'hxx;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s_mosi got %h want %h", tag, g, e);
      end
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (rx_got.size() > 0) ? rx_got.pop_front() : 8'hxx;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s_rx got %h want %h", tag, g, e);
      end
    end
    n_checks++;
    if (rx_got.size() != 0 || mosi_got.size() != 0) begin
      n_fail++;
      $display("FAIL %s_extra rx %0d mosi %0d want 0 0",
               tag, rx_got.size(), mosi_got.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({csn, sck, mosi} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_pins got %b want 100", {csn, sck, mosi});
    end
    n_checks++;
    if ({status, rx_byte} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_data got %h want 0000", {status, rx_byte});
    end
    n_checks++;
    if ({cmd_ready, tx_ready, rx_dv, status_dv, len_err, done, abort}
        !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 0",
        {cmd_ready, tx_ready, rx_dv, status_dv, len_err, done, abort});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_nop(input logic [7:0] st, input string tag);
    bit ok;
    int d0, s0;
    clear_sb();
    d0 = n_done;
    s0 = n_stat;
    slv_q.push_back(st);
    exp_mosi.push_back(OP_NOP);
    start_cmd(OP_NOP, '0, ok);
    if (ok) wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_frame got timeout want idle", tag);
    end
    check_sb(tag);
    n_checks++;
    if (status !== st || rx_dr !== st[STAT_RX_DR]) begin
      n_fail++;
      $display("FAIL %s_status got %h/%b want %h/%b",
               tag, status, rx_dr, st, st[STAT_RX_DR]);
    end
    n_checks++;
    if (n_done - d0 != 1 || n_stat - s0 != 1) begin
      n_fail++;
      $display("FAIL %s_pulses got done %0d stat %0d want 1 1",
               tag, n_done - d0, n_stat - s0);
    end
    n_checks++;
    if (sck_rises != 8 || lenerr_seen) begin
      n_fail++;
      $display("FAIL %s_sck got %0d lenerr %b want 8 0",
               tag, sck_rises, lenerr_seen);
    end
  endtask

  task automatic test_read_payload();
    bit ok;
    logic [7:0] pl[3];
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    pl[2] = 8'h33;
    clear_sb();
    slv_q.push_back(8'h0E);
    exp_mosi.push_back(OP_R_RX_PAYLOAD);
    start_cmd(OP_R_RX_PAYLOAD, LW'(3), ok);
    for (int i = 0; i < 3 && ok; i++) begin
      slv_q.push_back(pl[i]);
      exp_rx.push_back(pl[i]);
      exp_mosi.push_back(8'hFF);
      send_tx(8'hFF, ok);
    end
    if (ok) wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_frame got timeout want idle");
    end
    check_sb("rd");
    n_checks++;
    if (sck_rises != 32 || status !== 8'h0E || rx_dr !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_misc got sck %0d st %h dr %b want 32 0e 0",
               sck_rises, status, rx_dr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0] b;
    clear_sb();
    slv_q.push_back(8'h0E);
    exp_mosi.push_back(OP_W_TX_PAYLOAD);
    start_cmd(OP_W_TX_PAYLOAD, LW'(4), ok);
    for (int i = 0; i < 4 && ok; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_mosi.push_back(b);
      exp_rx.push_back(8'h00);
      if (i == 2) begin
        for (int k = 0; k < 200 && !tx_ready; k++) @(negedge clk);
        stall_watch = 1'b1;
        repeat (50) @(negedge clk);
        stall_watch = 1'b0;
      end
      send_tx(b, ok);
    end
    if (ok) wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_frame got timeout want idle");
    end
    check_sb("stall");
    n_checks++;
    if (stall_bad != 0 || sck_rises != 40) begin
      n_fail++;
      $display("FAIL stall_pins got bad %0d sck %0d want 0 40",
               stall_bad, sck_rises);
    end
  endtask

  task automatic test_len_clamp();
    bit ok;
    clear_sb();
    exp_mosi.push_back(OP_W_TX_PAYLOAD);
    start_cmd(OP_W_TX_PAYLOAD, LW'(40), ok);
    n_checks++;
    if (lenerr_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_lenerr got %b want 1", lenerr_seen);
    end
    for (int i = 0; i < 32 && ok; i++) begin
      exp_mosi.push_back(8'(i * 7 + 3));
      exp_rx.push_back(8'h00);
      send_tx(8'(i * 7 + 3), ok);
    end
    if (ok) wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1 || sck_rises != 264) begin
      n_fail++;
      $display("FAIL clamp_bytes got ok %b sck %0d want 1 264",
               ok, sck_rises);
    end
    check_sb("clamp");
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb();
    start_cmd(OP_W_TX_PAYLOAD, LW'(4), ok);
    if (ok) send_tx(8'h12, ok);
    if (ok) send_tx(8'h34, ok);
    if (ok) send_tx(8'h56, ok);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ok !== 1'b1 || csn !== 1'b1 || sck !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pins got ok %b csn %b sck %b want 1 1 0",
               ok, csn, sck);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready got %b want 1", cmd_ready);
    end
    test_nop(8'h40, "rstmid");
  endtask

  task automatic test_timeout();
    bit ok;
    int a0, d0, cyc;
    clear_sb();
    a0 = n_abort;
    d0 = n_done;
    start_cmd(OP_W_TX_PAYLOAD, LW'(2), ok);
    if (ok) send_tx(8'hC3, ok);
    for (int k = 0; k < 200 && !tx_ready; k++) @(negedge clk);
    cyc = 0;
    while (n_abort == a0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
`ifdef SPI_BURST_TIMEOUT_EN
    n_checks++;
    if (cyc != 16 || csn !== 1'b1 || n_done != d0) begin
      n_fail++;
      $display("FAIL tmo_abort got cyc %0d csn %b done %0d want 16 1 %0d",
               cyc, csn, n_done, d0);
    end
    wait_idle(ok);
`else
    n_checks++;
    if (n_abort != a0 || csn !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_none got abort %0d csn %b rdy %b want %0d 0 1",
               n_abort, csn, tx_ready, a0);
    end
    if (ok) send_tx(8'h3C, ok);
    if (ok) wait_idle(ok);
`endif
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_frame got timeout want idle");
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_nop(8'h4E, "nop");
    test_read_payload();
    test_stall();
    test_len_clamp();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
